samp_drain: RTL and testbench

Read-side controller for the I/Q sample FIFO. It pops samples from the FIFO head only when the FIFO is non-empty and holds each one in an output register. It presents the sample downstream with a PushOut/StopIn handshake, paced to at most one sample every PACE_DIV clocks. It sits between the `fifo` block's read port and the downstream sample consumer (e.g. DAC/serializer), and flags missed sample slots as underruns.

---
 rtl/samp_drain_pkg.sv | 17 +
 rtl/samp_pace_cnt.sv | 32 +++
 rtl/samp_drain.sv | 97 +++++++++
 tb/tb_samp_drain.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/samp_drain_pkg.sv
// Shared sample package: I/Q sample struct and the read-side drain FSM states.
package samp_drain_pkg;

  localparam int unsigned SAMP_W = 24;

  typedef struct packed {
    logic [SAMP_W-1:0] I;
    logic [SAMP_W-1:0] Q;
  } Samp;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_STARVE
  } drain_state_e;

endpackage

// File: rtl/samp_pace_cnt.sv
// Output pacing counter: reloads to PACE_DIV-1, counts down to zero and holds
// there, and is forced to zero while the drain is idle.
module samp_pace_cnt #(
  parameter int unsigned PACE_DIV = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic reload,
  input  logic count_en,
  output logic zero
);

  localparam logic [15:0] RELOAD_VAL = 16'(PACE_DIV - 1);

  logic [15:0] pcnt;

  // Reload has priority; otherwise count down while active, clear while idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pcnt <= '0;
    end else if (reload) begin
      pcnt <= RELOAD_VAL;
    end else if (!count_en) begin
      pcnt <= '0;
    end else if (pcnt != '0) begin
      pcnt <= pcnt - 16'd1;
    end
  end

  assign zero = (pcnt == '0);

endmodule

// File: rtl/samp_drain.sv
// Read-side controller for the I/Q sample FIFO.
// Optional feature macro: SAMP_DRAIN_UNDERRUN_CNT_EN (saturating underrun counter).
module samp_drain
  import samp_drain_pkg::*;
#(
  parameter int unsigned PACE_DIV = 1,
  parameter int unsigned UCNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  Samp               fifo_samp,
  input  logic              fifo_empty,
  output logic              fifo_PullOut,
  input  logic              StopIn,
  output logic              PushOut,
  output logic [SAMP_W-1:0] SampIOut,
  output logic [SAMP_W-1:0] SampQOut,
  output logic              Underrun,
  output logic [UCNT_W-1:0] UnderrunCnt
);

  drain_state_e state;
  drain_state_e state_nxt;
  Samp          out_reg;
  logic         pcnt_zero;
  logic         xfer;
  logic         load;

  samp_pace_cnt #(
    .PACE_DIV (PACE_DIV)
  ) u_pace (
    .Clk      (Clk),
    .Reset    (Reset),
    .reload   (xfer | Underrun),
    .count_en (state != S_IDLE),
    .zero     (pcnt_zero)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (load) state_nxt = S_HOLD;
      S_HOLD:   if (xfer && !load) state_nxt = S_STARVE;
      S_STARVE: if (load) state_nxt = S_HOLD;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake, pop and underrun decode; the pop is guarded by fifo_empty.
  always_comb begin
    PushOut      = (state == S_HOLD) && pcnt_zero;
    xfer         = PushOut && !StopIn;
    load         = !fifo_empty && ((state != S_HOLD) || xfer);
    fifo_PullOut = load;
    Underrun     = (state == S_STARVE) && pcnt_zero;
  end

  // Output sample register, captured at the same edge the FIFO pops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_reg <= '0;
    end else if (load) begin
      out_reg <= fifo_samp;
    end
  end

  assign SampIOut = out_reg.I;
  assign SampQOut = out_reg.Q;

`ifdef SAMP_DRAIN_UNDERRUN_CNT_EN
  logic [UCNT_W-1:0] ucnt;

  // Saturating missed-slot counter, cleared only by reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ucnt <= '0;
    end else if (Underrun && (ucnt != '1)) begin
      ucnt <= ucnt + UCNT_W'(1);
    end
  end

  assign UnderrunCnt = ucnt;
`else
  assign UnderrunCnt = '0;
`endif

endmodule

// File: tb/tb_samp_drain.sv
// Bench for samp_drain: a FIFO model feeds one of two instances (PACE_DIV=1
// and PACE_DIV=4); transferred samples are checked against a scoreboard.
module tb_samp_drain;
  import samp_drain_pkg::*;

`ifdef SAMP_DRAIN_UNDERRUN_CNT_EN
  localparam int unsigned EXP_UCNT = 2;
`else
  localparam int unsigned EXP_UCNT = 0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        StopIn;
  Samp         fifo_samp;
  logic        empty_m;
  logic        sel;          // 0: u1 (PACE_DIV=1), 1: u4 (PACE_DIV=4)
  logic        e1, e4;

  logic        u1_pull, u1_push, u1_und;
  logic [23:0] u1_i, u1_q;
  logic [15:0] u1_cnt;
  logic        u4_pull, u4_push, u4_und;
  logic [23:0] u4_i, u4_q;
  logic [15:0] u4_cnt;

  assign e1 = sel ? 1'b1 : empty_m;
  assign e4 = sel ? empty_m : 1'b1;

  samp_drain #(.PACE_DIV(1), .UCNT_W(16)) u1 (
    .Clk(Clk), .Reset(Reset), .fifo_samp(fifo_samp), .fifo_empty(e1),
    .fifo_PullOut(u1_pull), .StopIn(StopIn), .PushOut(u1_push),
    .SampIOut(u1_i), .SampQOut(u1_q), .Underrun(u1_und), .UnderrunCnt(u1_cnt)
  );

  samp_drain #(.PACE_DIV(4), .UCNT_W(16)) u4 (
    .Clk(Clk), .Reset(Reset), .fifo_samp(fifo_samp), .fifo_empty(e4),
    .fifo_PullOut(u4_pull), .StopIn(StopIn), .PushOut(u4_push),
    .SampIOut(u4_i), .SampQOut(u4_q), .Underrun(u4_und), .UnderrunCnt(u4_cnt)
  );

  Samp fifo_q[$];
  Samp exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic        pull_s, push_s, und_s;
  logic [23:0] i_s, q_s;
  logic [15:0] cnt_s;

  typedef struct {
    logic        stop;
    logic        exp_pull;
    logic        exp_push;
    logic        exp_und;
    logic [23:0] exp_i;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_fifo();
    empty_m   = (fifo_q.size() == 0);
    fifo_samp = empty_m ? '0 : fifo_q[0];
  endtask

  task automatic push_samp(input logic [23:0] i, input logic [23:0] q);
    Samp s;
    s.I = i;
    s.Q = q;
    fifo_q.push_back(s);
    exp_q.push_back(s);
    update_fifo();
  endtask

  // One clock: sample at negedge, scoreboard any transfer, pop FIFO model at posedge.
  task automatic cycle();
    Samp e;
    update_fifo();
    @(negedge Clk);
    pull_s = sel ? u4_pull : u1_pull;
    push_s = sel ? u4_push : u1_push;
    und_s  = sel ? u4_und  : u1_und;
    i_s    = sel ? u4_i    : u1_i;
    q_s    = sel ? u4_q    : u1_q;
    cnt_s  = sel ? u4_cnt  : u1_cnt;
    if (empty_m) chk("pull_while_empty", pull_s, 0);
    chk("unselected_pull", sel ? u1_pull : u4_pull, 0);
    if (push_s && !StopIn) begin
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", push_s, 0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_I", i_s, e.I);
        chk("xfer_Q", q_s, e.Q);
      end
    end
    @(posedge Clk);
    if (pull_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    update_fifo();
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    StopIn = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    update_fifo();
    #1;
    chk("rst_push1", u1_push, 0);
    chk("rst_pull1", u1_pull, 0);
    chk("rst_I1", u1_i, 0);
    chk("rst_und1", u1_und, 0);
    chk("rst_cnt1", u1_cnt, 0);
    chk("rst_push4", u4_push, 0);
    chk("rst_Q4", u4_q, 0);
    chk("rst_cnt4", u4_cnt, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  vec_t vecs[6];
  int   pops;
  int   und_total;

  initial begin
    Reset  = 1'b1;
    StopIn = 1'b0;
    sel    = 1'b0;
    update_fifo();

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'd1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'd2};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'd3};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'd3};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'd3};

    // Three samples at PACE_DIV=1, then starvation.
    sel = 1'b0;
    do_reset();
    push_samp(24'd1, 24'hFFFFFF);
    push_samp(24'd2, 24'hFFFFFE);
    push_samp(24'd3, 24'hFFFFFD);
    for (int unsigned k = 0; k < 6; k++) begin
      StopIn = vecs[k].stop;
      cycle();
      chk($sformatf("t1_pull[%0d]", k), pull_s, vecs[k].exp_pull);
      chk($sformatf("t1_push[%0d]", k), push_s, vecs[k].exp_push);
      chk($sformatf("t1_und[%0d]", k), und_s, vecs[k].exp_und);
      chk($sformatf("t1_I[%0d]", k), i_s, vecs[k].exp_i);
    end

    // Backpressure: 8 samples, StopIn high for 10 cycles.
    do_reset();
    for (int unsigned k = 0; k < 8; k++) push_samp(24'(16 + k), 24'(3 * k));
    StopIn = 1'b1;
    pops = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      cycle();
      pops += int'(pull_s);
      chk("stop_und", und_s, 0);
      if (k > 0) begin
        chk("stop_push", push_s, 1);
        chk("stop_I", i_s, 24'd16);
      end
    end
    chk("stop_pops", pops, 1);
    StopIn = 1'b0;
    #1;
    chk("comb_pull_go", u1_pull, 1);
    chk("comb_push_go", u1_push, 1);
    StopIn = 1'b1;
    #1;
    chk("comb_pull_stop", u1_pull, 0);
    StopIn = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      cycle();
      chk("b2b_push", push_s, 1);
    end
    cycle();
    chk("b2b_end_push", push_s, 0);
    chk("b2b_end_und", und_s, 1);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // PACE_DIV=4 with a full FIFO: one transfer every 4th clock.
    sel = 1'b1;
    do_reset();
    for (int unsigned k = 0; k < 12; k++) push_samp(24'(100 + k), 24'(200 + k));
    for (int unsigned c = 0; c < 21; c++) begin
      cycle();
      if (c == 0) begin
        chk("pace_first_pull", pull_s, 1);
        chk("pace_first_push", push_s, 0);
      end else begin
        chk("pace_push", push_s, ((c - 1) % 4) == 0);
        chk("pace_pull", pull_s, ((c - 1) % 4) == 0);
      end
    end

    // PACE_DIV=4 underrun: drain after two samples, refill 9 cycles later.
    do_reset();
    push_samp(24'h000AAA, 24'h000BBB);
    push_samp(24'h000CCC, 24'h000DDD);
    und_total = 0;
    for (int unsigned c = 0; c < 18; c++) begin
      if (c == 14) push_samp(24'h000EEE, 24'h000FFF);
      cycle();
      und_total += int'(und_s);
      chk("ur_und", und_s, (c == 9) || (c == 13));
      if (c == 5) chk("ur_push_s2", push_s, 1);
      if (c == 14) chk("ur_refill_pull", pull_s, 1);
      if (c == 17) begin
        chk("ur_refill_push", push_s, 1);
        chk("ur_cnt", cnt_s, EXP_UCNT);
      end
    end
    chk("ur_total", und_total, 2);

    // Empty FIFO with random backpressure: stays idle.
    sel = 1'b0;
    do_reset();
    for (int unsigned k = 0; k < 100; k++) begin
      StopIn = 1'($urandom_range(0, 1));
      cycle();
      chk("idle_push", push_s, 0);
      chk("idle_und", und_s, 0);
    end
    StopIn = 1'b0;

    // Asynchronous reset while holding a sample.
    do_reset();
    push_samp(24'h7FFFFF, 24'h123456);
    StopIn = 1'b1;
    cycle();
    cycle();
    chk("hold_push", push_s, 1);
    chk("hold_I", i_s, 24'h7FFFFF);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_push", u1_push, 0);
    chk("arst_I", u1_i, 0);
    chk("arst_Q", u1_q, 0);
    chk("arst_cnt", u1_cnt, 0);
    fifo_q.delete();
    exp_q.delete();
    StopIn = 1'b0;
    update_fifo();
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    push_samp(24'd5, 24'd6);
    cycle();
    chk("post_rst_pull", pull_s, 1);
    chk("post_rst_push", push_s, 0);
    cycle();
    chk("post_rst_push2", push_s, 1);
    chk("post_rst_I", i_s, 24'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
